// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants, state encoding and magnitude helper for the mult/div unit
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Unsigned magnitude of a two's complement operand; 33 bits so |0x80000000| is exact.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
    mag = x[WIDTH-1] ? ({1'b0, ~x} + (WIDTH+1)'(1)) : {1'b0, x};
  endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// rtl/multdiv_unit_if.sv - start/operand/result signal bundle between control and the mult/div unit
interface multdiv_unit_if;
  import multdiv_pkg::*;

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - iteration step counter with load-zero, increment enable and terminal count
module iter_counter
  import multdiv_pkg::*;
(
  input  logic clk_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: a start reloads zero, otherwise advance once per datapath step.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit shift-add multiplier and restoring divider
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  multdiv_unit_if.slave   bus
);

  state_e state_q, state_d;

  logic             start, stepping, tc;
  logic [WIDTH:0]   mag_a, mag_b;

  logic             neg_q, div_zero_q, div_ovf_q;
  logic [2*WIDTH:0] acc_q;       // {partial product high 33 bits, multiplier bits still to consume}
  logic [WIDTH:0]   mcand_q;
  logic [WIDTH:0]   rem_q;       // partial remainder
  logic [WIDTH-1:0] quo_q;       // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH:0]   divisor_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic [WIDTH+1:0]   mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_exc;
  logic [WIDTH+1:0]   div_shift, div_diff;
  logic               div_fit;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next, div_quot;

  assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign stepping = (state_q == MUL) || (state_q == DIV);
  assign mag_a    = mag(bus.data_operandA);
  assign mag_b    = mag(bus.data_operandB);

  iter_counter u_iter_counter (
    .clk_i  (clk),
    .clr_i  (clr),
    .load_i (start),
    .en_i   (stepping),
    .tc_o   (tc)
  );

  // One radix-2 step of each datapath plus sign fix-up of the final value.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    mul_prod  = neg_q ? (~mul_next[2*WIDTH-1:0] + (2*WIDTH)'(1)) : mul_next[2*WIDTH-1:0];
    mul_exc   = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || !(|mul_prod[2*WIDTH-1:WIDTH-1]));
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor_q};
    div_fit   = !div_diff[WIDTH+1];
    rem_next  = div_fit ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
    quo_next  = {quo_q[WIDTH-2:0], div_fit};
    div_quot  = neg_q ? (~quo_next + WIDTH'(1)) : quo_next;
  end

  // Next state: a start always wins (multiply over divide), otherwise walk the sequence.
  always_comb begin
    state_d = state_q;
    if (bus.ctrl_MULT) begin
      state_d = MUL;
    end else if (bus.ctrl_DIV) begin
      state_d = DIV;
    end else begin
      case (state_q)
        MUL, DIV: if (tc) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on start, one datapath step per cycle, result load on the last step.
  always_ff @(posedge clk) begin
    if (clr) begin
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else if (start) begin
      neg_q      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div_zero_q <= (bus.data_operandB == '0);
      div_ovf_q  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
      acc_q      <= {{(WIDTH+1){1'b0}}, mag_b[WIDTH-1:0]};
      mcand_q    <= mag_a;
      rem_q      <= '0;
      quo_q      <= mag_a[WIDTH-1:0];
      divisor_q  <= mag_b;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else if (state_q == MUL) begin
      acc_q <= mul_next;
      if (tc) begin
        result_q <= mul_prod[WIDTH-1:0];
        exc_q    <= mul_exc;
      end
    end else if (state_q == DIV) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      if (tc) begin
        if (div_zero_q) begin
          result_q <= '0;
          exc_q    <= 1'b1;
        end else if (div_ovf_q) begin
          result_q <= {1'b1, {(WIDTH-1){1'b0}}};
          exc_q    <= 1'b1;
        end else begin
          result_q <= div_quot;
          exc_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = stepping;

endmodule
